// File: rtl/tanh_pkg.sv
// Shared constants and sequencer FSM encoding for the tanh job sequencer.
// Saturation constants serve the optional TANH_SAT_BYPASS_EN build.
package tanh_pkg;

   localparam int unsigned TanhWidth = 16;
   localparam int unsigned TanhFrac  = 12;

   localparam logic [TanhWidth-1:0] TanhOne       = 16'h1000;
   localparam logic [TanhWidth-1:0] TanhSatThresh = 16'h4000;
   localparam logic [TanhWidth-1:0] TanhSatPos    = TanhOne - 16'd1;
   localparam logic [TanhWidth-1:0] TanhSatNeg    = 16'd0 - TanhSatPos;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StLaunch   = 3'd1,
      StWaitBusy = 3'd2,
      StWaitDone = 3'd3,
      StHold     = 3'd4
   } seq_state_e;

endpackage

// File: rtl/tanh_in_fifo.sv
// Synchronous operand FIFO with push/pop, full/empty flags and occupancy count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module tanh_in_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             wdata_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             rdata_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/tanh_job_sequencer.sv
// Feeds buffered x operands one at a time to the tanh core and holds each result
// on a valid/ready port. Define TANH_SAT_BYPASS_EN to short-circuit saturating operands.
module tanh_job_sequencer
   import tanh_pkg::*;
#(
   parameter int unsigned     WIDTH      = TanhWidth,
   parameter int unsigned     FRAC       = TanhFrac,
   parameter int unsigned     DEPTH      = 4,
   parameter logic [WIDTH-1:0] SAT_THRESH = WIDTH'(TanhSatThresh)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   output logic             core_start,
   output logic [WIDTH-1:0] core_x,
   input  logic             core_ready,
   input  logic [WIDTH-1:0] core_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             busy
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);

   if (FRAC >= WIDTH - 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       $signed(SAT_THRESH) <= 0) begin : g_bad_cfg
      $error("tanh_job_sequencer: unsupported parameter set");
   end

   seq_state_e       state_q, state_d;
   logic [WIDTH-1:0] core_x_q, core_x_d;
   logic [WIDTH-1:0] out_y_q, out_y_d;
   logic             core_start_q, core_start_d;
   logic             out_valid_q, out_valid_d;

   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_head;
   logic [CntW-1:0]  fifo_count;

   logic             head_sat;
   logic [WIDTH-1:0] sat_y;

   tanh_in_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_in_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (in_valid),
      .wdata_i (in_x),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

`ifdef TANH_SAT_BYPASS_EN
   localparam logic [WIDTH-1:0] One    = WIDTH'(1) << FRAC;
   localparam logic [WIDTH-1:0] SatPos = One - WIDTH'(1);
   localparam logic [WIDTH-1:0] SatNeg = WIDTH'(0) - SatPos;

   // Two signed compares instead of |x| so the most-negative code cannot overflow.
   assign head_sat = ($signed(fifo_head) >= $signed(SAT_THRESH)) ||
                     ($signed(fifo_head) <= -$signed(SAT_THRESH));
   assign sat_y    = fifo_head[WIDTH-1] ? SatNeg : SatPos;
`else
   assign head_sat = 1'b0;
   assign sat_y    = '0;
`endif

   always_comb begin
      state_d      = state_q;
      core_x_d     = core_x_q;
      out_y_d      = out_y_q;
      out_valid_d  = out_valid_q;
      core_start_d = 1'b0;
      fifo_pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               if (head_sat) begin
                  fifo_pop    = 1'b1;
                  out_y_d     = sat_y;
                  out_valid_d = 1'b1;
                  state_d     = StHold;
               end else if (core_ready) begin
                  fifo_pop     = 1'b1;
                  core_x_d     = fifo_head;
                  core_start_d = 1'b1;
                  state_d      = StLaunch;
               end
            end
         end
         StLaunch: begin
            state_d = StWaitBusy;
         end
         StWaitBusy: begin
            if (!core_ready) begin
               state_d = StWaitDone;
            end
         end
         StWaitDone: begin
            if (core_ready) begin
               out_y_d     = core_result;
               out_valid_d = 1'b1;
               state_d     = StHold;
            end
         end
         StHold: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         core_x_q     <= '0;
         out_y_q      <= '0;
         core_start_q <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         core_x_q     <= core_x_d;
         out_y_q      <= out_y_d;
         core_start_q <= core_start_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign in_ready   = !fifo_full;
   assign core_start = core_start_q;
   assign core_x     = core_x_q;
   assign out_valid  = out_valid_q;
   assign out_y      = out_y_q;
   assign busy       = (fifo_count != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_tanh_job_sequencer.sv
// Bench for tanh_job_sequencer: stub core, job-queue reference model, directed and random phases.
module tb_tanh_job_sequencer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_x = '0;
   logic        out_ready = 1'b0;
   logic        core_ready = 1'b1;
   logic [15:0] core_result = '0;
   logic        in_ready, core_start, out_valid, busy;
   logic [15:0] core_x, out_y;

   int checks = 0;
   int errors = 0;

   tanh_job_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_x        (in_x),
      .core_start  (core_start),
      .core_x      (core_x),
      .core_ready  (core_ready),
      .core_result (core_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_y       (out_y),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- stub core ----------------
   bit          fixed_en = 1'b0;
   logic [15:0] fixed_val = '0;
   bit          force_busy = 1'b0;
   bit          lat_rand = 1'b0;
   int          lat = 3;
   int          stub_cnt = 0;
   logic [15:0] stub_x = '0;

   function automatic logic [15:0] core_f(input logic [15:0] x);
      return fixed_en ? fixed_val : 16'(x * 16'd3 + 16'h0123);
   endfunction

   always @(posedge clk) begin
      if (stub_cnt != 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1) begin
            core_ready  <= 1'b1;
            core_result <= core_f(stub_x);
         end
      end else if (core_start) begin
         core_ready <= 1'b0;
         stub_x     <= core_x;
         stub_cnt   <= lat_rand ? int'($urandom_range(1, 6)) : lat;
      end else begin
         core_ready <= !force_busy;
      end
   end

   // ---------------- reference model ----------------
   function automatic bit is_sat(input logic [15:0] x);
`ifdef TANH_SAT_BYPASS_EN
      return ($signed(x) >= 16'sh4000) || ($signed(x) <= -16'sh4000);
`else
      return (x != x);
`endif
   endfunction

   function automatic logic [15:0] ref_y(input logic [15:0] x);
      if (is_sat(x)) return x[15] ? 16'hF001 : 16'h0FFF;
      return core_f(x);
   endfunction

   logic [15:0] pending[$];
   logic [15:0] out_log[$];
   logic [15:0] job_x = '0, exp_y = '0, last_start_x = '0;
   bit          inflight = 0, saw_low = 0, ov_m = 0;
   bit          st_s = 0, by_s = 0, ri_s = 0, hs_s = 0;
   int          n_starts = 0;

   always @(negedge clk) begin
      if (rst) begin
         pending.delete();
         inflight = 0; saw_low = 0; ov_m = 0;
         st_s = 0; by_s = 0; ri_s = 0; hs_s = 0;
      end else begin
         if (hs_s) ov_m = 0;
         if (st_s) begin
            chk("core_x_launch", core_x, pending[0]);
            job_x = pending.pop_front();
            inflight = 1; saw_low = 0;
            n_starts++;
            last_start_x = core_x;
         end
         if (by_s) begin
            exp_y = ref_y(pending.pop_front());
            ov_m = 1;
         end
         if (ri_s) begin
            exp_y = core_f(job_x);
            inflight = 0;
            ov_m = 1;
         end
         chk("core_start", core_start, st_s);
         chk("out_valid", out_valid, ov_m);
         chk("in_ready", in_ready, pending.size() < DEPTH);
         chk("busy", busy, pending.size() != 0 || inflight || ov_m);
         if (ov_m) chk("out_y", out_y, exp_y);
         if (inflight) chk("core_x_hold", core_x, job_x);
         st_s = 0; by_s = 0; ri_s = 0;
         hs_s = ov_m && out_ready;
         if (hs_s) out_log.push_back(out_y);
         if (inflight) begin
            if (!core_ready) saw_low = 1;
            else if (saw_low) ri_s = 1;
         end else if (!ov_m && pending.size() != 0) begin
            if (is_sat(pending[0])) by_s = 1;
            else if (core_ready) st_s = 1;
         end
         if (in_valid && pending.size() < DEPTH) pending.push_back(in_x);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] x);
      int n = 0;
      in_valid = 1'b1;
      in_x = x;
      while (!in_ready && n < 200) begin
         cyc();
         n++;
      end
      cyc();
      in_valid = 1'b0;
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL push_timeout: got in_ready=0 want 1 within 200 cycles");
      end
   endtask

   task automatic wait_ov();
      int n = 0;
      while (!out_valid && n < 100) begin
         cyc();
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL out_valid_timeout: got 0 want 1 within 100 cycles");
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || out_valid || !core_ready) && n < 300) begin
         cyc();
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL idle_timeout: got busy=%0d want 0 within 300 cycles", busy);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish by 500000");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, o0, n;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_core_x", core_x, 16'h0000);
      chk("rst_out_y", out_y, 16'h0000);

      // single job
      fixed_en = 1'b1; fixed_val = 16'h0765; lat = 6;
      s0 = n_starts;
      push(16'h0800);
      wait_ov();
      chk("single_out_y", out_y, 16'h0765);
      chk("single_starts", n_starts - s0, 1);
      chk("single_core_x", last_start_x, 16'h0800);
      out_ready = 1'b1;
      wait_idle();
      chk("single_busy_end", busy, 0);
      fixed_en = 1'b0;

      // burst of five
      lat = 3;
      s0 = n_starts;
      o0 = out_log.size();
      push(16'h0100); push(16'h0200); push(16'h0300); push(16'h0400); push(16'h0500);
      chk("burst_full", in_ready, 0);
      wait_idle();
      chk("burst_starts", n_starts - s0, 5);
      chk("burst_y0", out_log[o0], 16'h0423);
      chk("burst_y1", out_log[o0+1], 16'h0723);
      chk("burst_y2", out_log[o0+2], 16'h0A23);
      chk("burst_y3", out_log[o0+3], 16'h0D23);
      chk("burst_y4", out_log[o0+4], 16'h1023);

      // backpressure
      out_ready = 1'b0; lat = 2;
      s0 = n_starts;
      push(16'h0A00); push(16'h0B00);
      wait_ov();
      repeat (20) cyc();
      chk("bp_out_y", out_y, 16'h1F23);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_starts", n_starts - s0, 1);
      out_ready = 1'b1;
      wait_idle();
      chk("bp_starts_end", n_starts - s0, 2);

      // core busy while FIFO non-empty
      force_busy = 1'b1;
      cyc(); cyc();
      s0 = n_starts;
      push(16'h0C00);
      repeat (10) cyc();
      chk("cb_no_start", n_starts - s0, 0);
      chk("cb_busy", busy, 1);
      force_busy = 1'b0;
      wait_idle();
      chk("cb_starts", n_starts - s0, 1);

      // reset mid-job
      lat = 8;
      s0 = n_starts;
      o0 = out_log.size();
      push(16'h0100); push(16'h0200); push(16'h0300);
      n = 0;
      while (n_starts == s0 && n < 100) begin
         cyc();
         n++;
      end
      repeat (4) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      repeat (15) cyc();
      chk("mid_rst_no_output", out_log.size() - o0, 0);
      wait_idle();

`ifdef TANH_SAT_BYPASS_EN
      lat = 3;
      s0 = n_starts;
      o0 = out_log.size();
      push(16'h5000); push(16'h8000);
      wait_idle();
      chk("sat_pos", out_log[o0], 16'h0FFF);
      chk("sat_neg", out_log[o0+1], 16'hF001);
      chk("sat_no_start", n_starts - s0, 0);
`endif

      // randomized traffic
      lat_rand = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         in_valid  = ($urandom_range(0, 9) < 6);
         in_x      = 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 399) == 0);
         cyc();
      end
      in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
